// File: rtl/mem_port_arb_if.sv
// Bundle of the I-cache, D-cache and shared memory port signals seen by the
// memory port arbiter, plus the arbiter status outputs.
interface mem_port_arb_if;
  logic [63:0]  iReqAddr;
  logic         iReqOE;
  logic [4:0]   iReqOp;
  logic [127:0] iOutData;
  logic [1:0]   iOutOK;

  logic [63:0]  dReqAddr;
  logic [127:0] dReqData;
  logic         dReqOE;
  logic         dReqWR;
  logic [4:0]   dReqOp;
  logic [127:0] dOutData;
  logic [1:0]   dOutOK;

  logic [127:0] memPcData;
  logic [1:0]   memPcOK;
  logic [127:0] memOutData;
  logic [63:0]  memPcAddr;
  logic         memPcOE;
  logic         memPcWR;
  logic [4:0]   memPcOp;

  logic [1:0]   arbGrant;
  logic         arbFault;

  // arbiter side
  modport slave (
    input  iReqAddr, iReqOE, iReqOp,
    output iOutData, iOutOK,
    input  dReqAddr, dReqData, dReqOE, dReqWR, dReqOp,
    output dOutData, dOutOK,
    input  memPcData, memPcOK,
    output memOutData, memPcAddr, memPcOE, memPcWR, memPcOp,
    output arbGrant, arbFault
  );

  // requesters / memory side
  modport master (
    output iReqAddr, iReqOE, iReqOp,
    input  iOutData, iOutOK,
    output dReqAddr, dReqData, dReqOE, dReqWR, dReqOp,
    input  dOutData, dOutOK,
    output memPcData, memPcOK,
    input  memOutData, memPcAddr, memPcOE, memPcWR, memPcOp,
    input  arbGrant, arbFault
  );
endinterface

// File: rtl/mem_port_arb.sv
// Two-requester (I-cache / D-cache) arbiter for a single memory port.
// Round-robin on contention, grants held until the owner goes idle, with a
// hold timeout that raises a sticky fault.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no owner; arbitrate among active requesters
// GRANT_I   | I-cache owns the memory port
// GRANT_D   | D-cache owns the memory port
// RELEASE   | one-cycle bus turnaround after a grant ends
module mem_port_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  mem_port_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_OK    = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;   // 0 = I, 1 = D
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       fault_q, fault_d;

  logic i_act, d_act, g_act, in_grant, mem_ok, timeout_hit, fault_now;

  // Request decode and timeout detection for the current owner
  always_comb begin
    i_act       = bus.iReqOE;
    d_act       = bus.dReqOE | bus.dReqWR;
    in_grant    = (state_q == S_GRANT_I) || (state_q == S_GRANT_D);
    g_act       = (state_q == S_GRANT_I) ? i_act : d_act;
    mem_ok      = (bus.memPcOK == ST_OK);
    timeout_hit = in_grant && (hold_cnt_q == TO_LAST) && !mem_ok;
    // an owner that is already letting go does not get a fault report
    fault_now   = timeout_hit && g_act;
  end

  // Next-state: arbitration, grant hold/release, hold counter, sticky fault
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    fault_d      = fault_q;
    case (state_q)
      S_IDLE: begin
        if (i_act && (!d_act || last_grant_q)) begin
          state_d      = S_GRANT_I;
          last_grant_d = 1'b0;
          hold_cnt_d   = 8'd0;
        end else if (d_act) begin
          state_d      = S_GRANT_D;
          last_grant_d = 1'b1;
          hold_cnt_d   = 8'd0;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (!g_act || timeout_hit) state_d = S_RELEASE;
        if (fault_now) fault_d = 1'b1;
        if (mem_ok) hold_cnt_d = 8'd0;
        else if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= 8'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      fault_q      <= fault_d;
    end
  end

  // Port steering: owner mirrors onto memory, others see HOLD/READY
  always_comb begin
    bus.memPcAddr  = '0;
    bus.memPcOE    = 1'b0;
    bus.memPcWR    = 1'b0;
    bus.memPcOp    = '0;
    bus.memOutData = '0;
    bus.iOutData   = '0;
    bus.dOutData   = '0;
    bus.iOutOK     = i_act ? ST_HOLD : ST_READY;
    bus.dOutOK     = d_act ? ST_HOLD : ST_READY;
    if (state_q == S_GRANT_I) begin
      bus.memPcAddr = bus.iReqAddr;
      bus.memPcOE   = bus.iReqOE;
      bus.memPcOp   = bus.iReqOp;
      bus.iOutData  = bus.memPcData;
      bus.iOutOK    = fault_now ? ST_FAULT : bus.memPcOK;
    end else if (state_q == S_GRANT_D) begin
      bus.memPcAddr  = bus.dReqAddr;
      bus.memPcOE    = bus.dReqOE;
      bus.memPcWR    = bus.dReqWR;
      bus.memPcOp    = bus.dReqOp;
      bus.memOutData = bus.dReqData;
      bus.dOutData   = bus.memPcData;
      bus.dOutOK     = fault_now ? ST_FAULT : bus.memPcOK;
    end
    bus.arbGrant = state_q;
    bus.arbFault = fault_q;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a random
// phase, every cycle compared against an ownership-level reference model.
module tb_mem_port_arb;

  localparam int TIMEOUT = 255;
  localparam logic [1:0] READY = 2'b00, OK = 2'b01, HOLD = 2'b10, FAULT = 2'b11;

  logic clock, reset;
  mem_port_arb_if bus ();

  mem_port_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: who owns the port, turnaround flag, history
  int m_owner;   // 0 none, 1 I-cache, 2 D-cache
  bit m_rel;
  int m_last;    // 1 = I served last, 2 = D served last
  int m_cnt;
  int m_age;     // cycles spent by the current owner
  bit m_fault;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit act(input int who);
    if (who == 1) return bus.iReqOE;
    if (who == 2) return bus.dReqOE | bus.dReqWR;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_rel = 0; m_last = 2; m_cnt = 0; m_age = 0; m_fault = 0;
  endtask

  function automatic bit model_fault_now();
    return (m_owner != 0) && act(m_owner) && (m_cnt == TIMEOUT - 1) && (bus.memPcOK != OK);
  endfunction

  task automatic model_advance();
    bit fnow;
    if (!reset) begin
      model_reset();
      return;
    end
    fnow = model_fault_now();
    if (m_rel) begin
      m_rel = 0;
    end else if (m_owner == 0) begin
      if (act(1) && act(2)) m_owner = (m_last == 1) ? 2 : 1;
      else if (act(1))      m_owner = 1;
      else if (act(2))      m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner; m_cnt = 0; m_age = 0;
      end
    end else if (!act(m_owner) || (m_cnt == TIMEOUT - 1 && bus.memPcOK != OK)) begin
      if (fnow) m_fault = 1;
      m_owner = 0; m_rel = 1;
    end else begin
      m_age++;
      if (bus.memPcOK == OK) m_cnt = 0;
      else if (m_cnt < 255)  m_cnt++;
    end
  endtask

  task automatic check_model();
    logic [63:0]  ea;
    logic         eoe, ewr;
    logic [4:0]   eop;
    logic [127:0] eod, eid, edd;
    logic [1:0]   eik, edk, eg;
    bit fnow;
    fnow = model_fault_now();
    ea = '0; eoe = 0; ewr = 0; eop = '0; eod = '0; eid = '0; edd = '0;
    eik = act(1) ? HOLD : READY;
    edk = act(2) ? HOLD : READY;
    if (m_owner == 1) begin
      ea = bus.iReqAddr; eoe = bus.iReqOE; eop = bus.iReqOp;
      eid = bus.memPcData; eik = fnow ? FAULT : bus.memPcOK;
    end else if (m_owner == 2) begin
      ea = bus.dReqAddr; eoe = bus.dReqOE; ewr = bus.dReqWR; eop = bus.dReqOp;
      eod = bus.dReqData; edd = bus.memPcData; edk = fnow ? FAULT : bus.memPcOK;
    end
    eg = m_rel ? 2'd3 : 2'(m_owner);
    chk("arbGrant",   128'(bus.arbGrant),   128'(eg));
    chk("arbFault",   128'(bus.arbFault),   128'(m_fault));
    chk("memPcAddr",  128'(bus.memPcAddr),  128'(ea));
    chk("memPcOE",    128'(bus.memPcOE),    128'(eoe));
    chk("memPcWR",    128'(bus.memPcWR),    128'(ewr));
    chk("memPcOp",    128'(bus.memPcOp),    128'(eop));
    chk("memOutData", bus.memOutData,       eod);
    chk("iOutData",   bus.iOutData,         eid);
    chk("iOutOK",     128'(bus.iOutOK),     128'(eik));
    chk("dOutData",   bus.dOutData,         edd);
    chk("dOutOK",     128'(bus.dOutOK),     128'(edk));
  endtask

  task automatic rnd_data();
    bus.iReqAddr  = {$urandom, $urandom};
    bus.iReqOp    = 5'($urandom);
    bus.dReqAddr  = {$urandom, $urandom};
    bus.dReqData  = {$urandom, $urandom, $urandom, $urandom};
    bus.memPcData = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // one clock: compare at negedge, advance model at posedge, return 1 after it
  task automatic cycle();
    @(negedge clock);
    check_model();
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  logic [63:0] addr_i;
  logic [1:0]  pat [8];

  initial begin
    pat[0] = 2'd1; pat[1] = 2'd1; pat[2] = 2'd3; pat[3] = 2'd0;
    pat[4] = 2'd2; pat[5] = 2'd2; pat[6] = 2'd3; pat[7] = 2'd0;
    reset = 1'b0;
    bus.iReqOE = 1; bus.dReqOE = 1; bus.dReqWR = 0; bus.dReqOp = '0;
    bus.memPcOK = OK;
    rnd_data();
    model_reset();
    #1;
    // outputs while reset is held, both requesters active
    check_model();
    @(posedge clock);
    #1;
    reset = 1'b1;

    // first arbitration after reset with both active grants I
    cycle();
    rnd_data(); addr_i = bus.iReqAddr;
    #1;
    chk("first_grant", 128'(bus.arbGrant), 128'(2'd1));
    chk("first_dhold", 128'(bus.dOutOK), 128'(HOLD));
    chk("first_addr",  128'(bus.memPcAddr), 128'(addr_i));

    // D store of 4 beats while I keeps asking
    bus.iReqOE = 0; bus.dReqOE = 0; bus.dReqWR = 1; bus.dReqOp = 5'd2;
    for (int k = 0; k < 3; k++) begin rnd_data(); cycle(); end
    bus.iReqOE = 1;
    for (int b = 0; b < 4; b++) begin
      rnd_data();
      #1;
      chk("store_grant", 128'(bus.arbGrant), 128'(2'd2));
      chk("store_wr",    128'(bus.memPcWR),  128'(1'b1));
      cycle();
    end
    bus.dReqWR = 0;
    rnd_data(); #1; chk("store_drop", 128'(bus.arbGrant), 128'(2'd2)); cycle();
    rnd_data(); #1; chk("store_rel",  128'(bus.arbGrant), 128'(2'd3)); cycle();
    rnd_data(); #1; chk("store_idle", 128'(bus.arbGrant), 128'(2'd0)); cycle();
    rnd_data(); #1; chk("store_nexti", 128'(bus.arbGrant), 128'(2'd1)); cycle();

    // alternating single-beat transfers with both sides always wanting more
    bus.iReqOE = 1; bus.dReqOE = 1; bus.dReqWR = 0; bus.memPcOK = OK;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      bus.iReqOE = !(m_owner == 1 && m_age >= 1);
      bus.dReqOE = !(m_owner == 2 && m_age >= 1);
      rnd_data();
      #1;
      chk("alt_pat", 128'(bus.arbGrant), 128'((k == 0) ? 2'd0 : pat[(k - 1) % 8]));
      cycle();
    end

    // timeout coinciding with the owner going idle: no fault
    bus.iReqOE = 0; bus.dReqOE = 1; bus.memPcOK = HOLD;
    do_reset();
    rnd_data(); cycle();
    for (int n = 1; n <= 255; n++) begin
      rnd_data();
      if (n == 255) bus.dReqOE = 0;
      #1;
      if (n == 255) chk("quiet_to_ok", 128'(bus.dOutOK), 128'(HOLD));
      cycle();
    end
    chk("quiet_to_grant", 128'(bus.arbGrant), 128'(2'd3));
    chk("quiet_to_fault", 128'(bus.arbFault), 128'(1'b0));

    // hold timeout on GRANT_D with memory stuck on HOLD
    bus.dReqOE = 1;
    do_reset();
    rnd_data(); cycle();
    for (int n = 1; n <= 255; n++) begin
      rnd_data();
      #1;
      chk("to_dok", 128'(bus.dOutOK), 128'((n == 255) ? FAULT : HOLD));
      if (n == 255) chk("to_fault_pre", 128'(bus.arbFault), 128'(1'b0));
      cycle();
    end
    chk("to_grant", 128'(bus.arbGrant), 128'(2'd3));
    chk("to_fault", 128'(bus.arbFault), 128'(1'b1));
    bus.memPcOK = OK;
    for (int k = 0; k < 10; k++) begin rnd_data(); cycle(); end
    chk("to_sticky", 128'(bus.arbFault), 128'(1'b1));

    // random traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bus.iReqOE  = ($urandom_range(0, 3) != 0);
      bus.dReqOE  = ($urandom_range(0, 2) == 0);
      bus.dReqWR  = ($urandom_range(0, 2) == 0);
      bus.dReqOp  = 5'($urandom);
      bus.memPcOK = 2'($urandom);
      rnd_data();
      cycle();
    end

    // reset in the middle of an I transfer
    bus.iReqOE = 1; bus.dReqOE = 0; bus.dReqWR = 0; bus.memPcOK = OK;
    do_reset();
    rnd_data(); cycle();
    rnd_data(); cycle();
    rnd_data();
    #1;
    chk("mid_grant_pre", 128'(bus.arbGrant), 128'(2'd1));
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_oe",    128'(bus.memPcOE),  128'(1'b0));
    chk("mid_rst_grant", 128'(bus.arbGrant), 128'(2'd0));
    chk("mid_rst_iok",   128'(bus.iOutOK),   128'(HOLD));
    chk("mid_rst_idata", bus.iOutData,       128'(0));
    check_model();
    bus.dReqOE = 1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    rnd_data(); cycle();
    #1;
    chk("post_rst_grant", 128'(bus.arbGrant), 128'(2'd1));
    rnd_data(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
